// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: one req/ack fetch in flight, one instruction
// held for decode, next fetch address formed from the PC/branch selects on the advance cycle.
module pc_fetch #(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter logic [31:0] IntVector   = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [1:0]  branch_sel_i,
  input  logic [31:0] br_offset_i,
  input  logic [25:0] jmp_index_i,
  input  logic [31:0] jmp_reg_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic [31:0] epc_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc4;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  always_comb begin
    pc4 = instr_pc_q + 32'd4;
    unique case (branch_sel_i)
      2'b01:   branch_target = {jmp_reg_i[31:2], 2'b00};
      2'b10:   branch_target = {pc4[31:28], jmp_index_i, 2'b00};
      default: branch_target = pc4 + (br_offset_i << 2);
    endcase
    unique case (pc_sel_i)
      2'b00:   next_pc = ResetVector;
      2'b01:   next_pc = IntVector;
      2'b10:   next_pc = pc4;
      default: next_pc = branch_target;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = fetch_pc_q;
          valid_d    = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        if (!stall_i) begin
          fetch_pc_d = next_pc;
          valid_d    = 1'b0;
          state_d    = StFetch;
          if (pc_sel_i == 2'b01) epc_d = pc4;
          // Flag register-jump targets whose low bits were dropped.
          misalign_d = (pc_sel_i == 2'b11) && (branch_sel_i == 2'b01) &&
                       (jmp_reg_i[1:0] != 2'b00);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetVector;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o    = (state_q == StFetch);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign epc_o         = epc_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: acts as instruction memory and tracks the expected
// fetch address, EPC and misalign pulse with a plain arithmetic model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [1:0]  branch_sel;
  logic [31:0] br_offset;
  logic [25:0] jmp_index;
  logic [31:0] jmp_reg;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] epc;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_addr;
  logic [31:0] exp_epc;
  logic        exp_mis;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_sel_i      (pc_sel),
    .branch_sel_i  (branch_sel),
    .br_offset_i   (br_offset),
    .jmp_index_i   (jmp_index),
    .jmp_reg_i     (jmp_reg),
    .stall_i       (stall),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .epc_o         (epc),
    .misalign_o    (misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference next-address rule, straight from the select encodings.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] ps,
                                             input logic [1:0] bs, input logic [31:0] off,
                                             input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (ps == 2'd0) return 32'h0000_0000;
    if (ps == 2'd1) return 32'h0000_0080;
    if (ps == 2'd2) return pc4;
    if (bs == 2'd1) return jr - (jr % 4);
    if (bs == 2'd2) return (pc4 & 32'hF000_0000) | (32'(idx) * 4);
    return pc4 + off * 4;
  endfunction

  task automatic scramble_ignored();
    pc_sel     = 2'($urandom);
    branch_sel = 2'($urandom);
    br_offset  = $urandom;
    jmp_index  = 26'($urandom);
    jmp_reg    = $urandom;
  endtask

  // Starts and ends on a negedge where the DUT should be in its first FETCH cycle.
  task automatic run_instr(input int lat, input int stalls, input logic [1:0] ps,
                           input logic [1:0] bs, input logic [31:0] off,
                           input logic [25:0] idx, input logic [31:0] jr,
                           input logic [31:0] data);
    logic [31:0] pc;
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, exp_addr);
    check_eq("fetch_valid", 32'(instr_valid), 32'd0);
    check_eq("misalign", 32'(misalign), 32'(exp_mis));
    check_eq("epc", epc, exp_epc);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      scramble_ignored();
      @(negedge clk);
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, exp_addr);
      check_eq("wait_misalign", 32'(misalign), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("dec_valid", 32'(instr_valid), 32'd1);
    check_eq("dec_instr", instr, data);
    check_eq("dec_pc", instr_pc, exp_addr);
    check_eq("dec_req", 32'(imem_req), 32'd0);
    check_eq("dec_misalign", 32'(misalign), 32'd0);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      scramble_ignored();
      @(negedge clk);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_instr", instr, data);
      check_eq("stall_pc", instr_pc, exp_addr);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_epc", epc, exp_epc);
    end
    stall = 1'b0;
    imem_ack = 1'($urandom);
    pc_sel = ps;
    branch_sel = bs;
    br_offset = off;
    jmp_index = idx;
    jmp_reg = jr;
    pc = exp_addr;
    exp_addr = model_next(pc, ps, bs, off, idx, jr);
    exp_mis = (ps == 2'd3) && (bs == 2'd1) && (jr % 4 != 0);
    if (ps == 2'd1) exp_epc = pc + 32'd4;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    scramble_ignored();
    exp_addr = 32'h0;
    exp_epc = 32'h0;
    exp_mis = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);

    // Directed cases: zero-wait first fetch, wrap, branch, J-type, misaligned jr, interrupt.
    run_instr(0, 0, 2'd3, 2'd1, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'h2000_0001);
    run_instr(0, 0, 2'd2, 2'd0, 32'h0, 26'h0, 32'h0, $urandom);
    run_instr(1, 0, 2'd3, 2'd1, 32'h0, 26'h0, 32'h0000_0100, $urandom);
    run_instr(0, 1, 2'd3, 2'd0, 32'hFFFF_FFFE, 26'h0, 32'h0, $urandom);
    check_eq("branch_back", exp_addr, 32'h0000_00FC);
    run_instr(0, 0, 2'd3, 2'd1, 32'h0, 26'h0, 32'h4000_0010, $urandom);
    run_instr(2, 0, 2'd3, 2'd2, 32'h0, 26'h000_0040, 32'h0, $urandom);
    run_instr(0, 0, 2'd3, 2'd1, 32'h0, 26'h0, 32'h0000_1237, $urandom);
    run_instr(0, 0, 2'd3, 2'd1, 32'h0, 26'h0, 32'h0000_0200, $urandom);
    run_instr(0, 3, 2'd1, 2'd0, 32'h0, 26'h0, 32'h0, $urandom);
    run_instr(0, 0, 2'd3, 2'd3, 32'h0000_0010, 26'h0, 32'h0, $urandom);

    for (int n = 0; n < 60; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                2'($urandom), 2'($urandom), $urandom, 26'($urandom), $urandom, $urandom);
    end

    // Reset in the second cycle of a 4-cycle memory wait.
    check_eq("pre_rst_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_req", 32'(imem_req), 32'd0);
    check_eq("abort_addr", imem_addr, 32'h0);
    check_eq("abort_valid", 32'(instr_valid), 32'd0);
    check_eq("abort_epc", epc, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("restart_idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("restart_valid", 32'(instr_valid), 32'd0);
    exp_addr = 32'h0;
    exp_epc = 32'h0;
    exp_mis = 1'b0;
    run_instr(1, 0, 2'd2, 2'd0, 32'h0, 26'h0, 32'h0, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
